// File: rtl/id_exe_reg.sv
// id_exe_reg: ARM decode -> execute pipeline register.
// Holds decoded control, operands, immediates, destination, PC and NZCV snapshot.
// flush squashes the entry being loaded (and wins over freeze), freeze holds
// everything, and a hazard slot (valid_in=0) loads as a bubble with control zeroed.
// A saturating counter tracks bubbles entering EXE.
// Build option: define ID_EXE_FWD_SRC_EN to add src1/src2 forwarding source registers.
module id_exe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic [3:0]        EXE_CMD_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              imm_in,
  input  logic [11:0]       Shift_operand_in,
  input  logic [23:0]       Signed_imm_24_in,
  input  logic [3:0]        Dest_in,
  input  logic [3:0]        SR_in,
`ifdef ID_EXE_FWD_SRC_EN
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
`endif
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              B,
  output logic              S,
  output logic [3:0]        EXE_CMD,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] Val_Rn,
  output logic [DATA_W-1:0] Val_Rm,
  output logic              imm,
  output logic [11:0]       Shift_operand,
  output logic [23:0]       Signed_imm_24,
  output logic [3:0]        Dest,
  output logic [3:0]        SR,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic load;
  logic bubble_evt;
  logic cnt_sat;

  assign load       = ~flush & ~freeze;
  assign bubble_evt = flush | (~freeze & ~valid_in);
  assign cnt_sat    = &bubble_cnt;

  // Control fields: zeroed on flush and on hazard slots so valid_out=0 never carries side effects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      WB_EN     <= 1'b0;
      MEM_R_EN  <= 1'b0;
      MEM_W_EN  <= 1'b0;
      B         <= 1'b0;
      S         <= 1'b0;
      EXE_CMD   <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
      WB_EN     <= 1'b0;
      MEM_R_EN  <= 1'b0;
      MEM_W_EN  <= 1'b0;
      B         <= 1'b0;
      S         <= 1'b0;
      EXE_CMD   <= '0;
    end else if (load) begin
      valid_out <= valid_in;
      WB_EN     <= valid_in & WB_EN_in;
      MEM_R_EN  <= valid_in & MEM_R_EN_in;
      MEM_W_EN  <= valid_in & MEM_W_EN_in;
      B         <= valid_in & B_in;
      S         <= valid_in & S_in;
      EXE_CMD   <= valid_in ? EXE_CMD_in : 4'd0;
    end
  end

  // Datapath fields: cleared on flush, otherwise copied on load even for bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC            <= '0;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      Shift_operand <= '0;
      Signed_imm_24 <= '0;
      Dest          <= '0;
      SR            <= '0;
    end else if (flush) begin
      PC            <= '0;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      Shift_operand <= '0;
      Signed_imm_24 <= '0;
      Dest          <= '0;
      SR            <= '0;
    end else if (load) begin
      PC            <= PC_in;
      Val_Rn        <= Val_Rn_in;
      Val_Rm        <= Val_Rm_in;
      imm           <= imm_in;
      Shift_operand <= Shift_operand_in;
      Signed_imm_24 <= Signed_imm_24_in;
      Dest          <= Dest_in;
      SR            <= SR_in;
    end
  end

`ifdef ID_EXE_FWD_SRC_EN
  // Forwarding source register numbers follow the datapath fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src1 <= '0;
      src2 <= '0;
    end else if (flush) begin
      src1 <= '0;
      src2 <= '0;
    end else if (load) begin
      src1 <= src1_in;
      src2 <= src2_in;
    end
  end
`endif

  // Bubble counter: saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (bubble_evt && !cnt_sat) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_exe_reg.sv
// Testbench for id_exe_reg: reference model pushes expected state per cycle
// into a queue; entries are popped and compared one cycle later.
module tb_id_exe_reg;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic freeze, flush, valid_in;
  logic WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in;
  logic [3:0]    EXE_CMD_in;
  logic [DW-1:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic          imm_in;
  logic [11:0]   Shift_operand_in;
  logic [23:0]   Signed_imm_24_in;
  logic [3:0]    Dest_in, SR_in;
  logic [3:0]    src1_in, src2_in;

  logic WB_EN, MEM_R_EN, MEM_W_EN, B, S;
  logic [3:0]    EXE_CMD;
  logic [DW-1:0] PC, Val_Rn, Val_Rm;
  logic          imm;
  logic [11:0]   Shift_operand;
  logic [23:0]   Signed_imm_24;
  logic [3:0]    Dest, SR;
  logic [3:0]    src1, src2;
  logic          valid_out;
  logic [CW-1:0] bubble_cnt;

  id_exe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .B_in(B_in), .S_in(S_in), .EXE_CMD_in(EXE_CMD_in), .PC_in(PC_in),
    .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .imm_in(imm_in),
    .Shift_operand_in(Shift_operand_in), .Signed_imm_24_in(Signed_imm_24_in),
    .Dest_in(Dest_in), .SR_in(SR_in),
`ifdef ID_EXE_FWD_SRC_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1(src1), .src2(src2),
`endif
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
    .EXE_CMD(EXE_CMD), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest(Dest),
    .SR(SR), .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

`ifndef ID_EXE_FWD_SRC_EN
  assign src1 = 4'd0;
  assign src2 = 4'd0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [4:0]    ctrl;      // WB_EN, MEM_R_EN, MEM_W_EN, B, S
    logic [3:0]    cmd;
    logic [DW-1:0] pc;
    logic [DW-1:0] rn;
    logic [DW-1:0] rm;
    logic          imm;
    logic [11:0]   sh;
    logic [23:0]   si;
    logic [3:0]    dest;
    logic [3:0]    sr;
    logic [7:0]    src;
    logic [CW-1:0] cnt;
  } st_t;

  st_t m;
  st_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic st_t observe();
    st_t o;
    o.valid = valid_out;
    o.ctrl  = {WB_EN, MEM_R_EN, MEM_W_EN, B, S};
    o.cmd   = EXE_CMD;
    o.pc    = PC;
    o.rn    = Val_Rn;
    o.rm    = Val_Rm;
    o.imm   = imm;
    o.sh    = Shift_operand;
    o.si    = Signed_imm_24;
    o.dest  = Dest;
    o.sr    = SR;
    o.src   = {src1, src2};
    o.cnt   = bubble_cnt;
    return o;
  endfunction

  task automatic compare(input string tag, input st_t e);
    st_t o;
    o = observe();
    check({tag, ".valid"}, 64'(o.valid), 64'(e.valid));
    check({tag, ".ctrl"},  64'({o.ctrl, o.cmd}), 64'({e.ctrl, e.cmd}));
    check({tag, ".pc"},    64'(o.pc), 64'(e.pc));
    check({tag, ".rn_rm"}, {o.rn, o.rm}, {e.rn, e.rm});
    check({tag, ".imm"},   64'({o.imm, o.sh, o.si}), 64'({e.imm, e.sh, e.si}));
    check({tag, ".dest"},  64'({o.dest, o.sr, o.src}), 64'({e.dest, e.sr, e.src}));
    check({tag, ".cnt"},   64'(o.cnt), 64'(e.cnt));
  endtask

  // Advance the reference model for the inputs currently driven.
  task automatic model_edge();
    logic [CW-1:0] c;
    logic bub;
    c   = m.cnt;
    bub = flush | (!freeze && !valid_in);
    if (flush) begin
      m = '0;
    end else if (!freeze) begin
      m.valid = valid_in;
      m.ctrl  = valid_in ? {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in} : 5'b0;
      m.cmd   = valid_in ? EXE_CMD_in : 4'd0;
      m.pc    = PC_in;
      m.rn    = Val_Rn_in;
      m.rm    = Val_Rm_in;
      m.imm   = imm_in;
      m.sh    = Shift_operand_in;
      m.si    = Signed_imm_24_in;
      m.dest  = Dest_in;
      m.sr    = SR_in;
`ifdef ID_EXE_FWD_SRC_EN
      m.src   = {src1_in, src2_in};
`endif
    end
    m.cnt = (bub && c != {CW{1'b1}}) ? c + 1'b1 : c;
  endtask

  task automatic step(input string tag);
    model_edge();
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      compare(tag, sb.pop_front());
    end
  endtask

  task automatic clear_inputs();
    freeze = 0; flush = 0; valid_in = 0;
    WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; B_in = 0; S_in = 0;
    EXE_CMD_in = 0; PC_in = 0; Val_Rn_in = 0; Val_Rm_in = 0; imm_in = 0;
    Shift_operand_in = 0; Signed_imm_24_in = 0; Dest_in = 0; SR_in = 0;
    src1_in = 0; src2_in = 0;
  endtask

  task automatic random_inputs();
    valid_in = ($urandom_range(9) < 7);
    {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in} = 5'($urandom);
    EXE_CMD_in = 4'($urandom);
    PC_in = $urandom; Val_Rn_in = $urandom; Val_Rm_in = $urandom;
    imm_in = 1'($urandom);
    Shift_operand_in = 12'($urandom);
    Signed_imm_24_in = 24'($urandom);
    Dest_in = 4'($urandom); SR_in = 4'($urandom);
    src1_in = 4'($urandom); src2_in = 4'($urandom);
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    m = '0;
    #12;
    compare("reset_state", m);
    @(negedge clk);
    rst = 1;

    // Load a real instruction.
    valid_in = 1; WB_EN_in = 1; EXE_CMD_in = 4'b0010; Val_Rn_in = 32'h1234; Dest_in = 4'd5;
    step("load");

    // Freeze for three cycles with different inputs, then release.
    freeze = 1;
    random_inputs();
    valid_in = 1;
    for (int i = 0; i < 3; i++) step("freeze_hold");
    freeze = 0;
    step("freeze_release");

    // Flush beats freeze.
    freeze = 1; flush = 1; valid_in = 1; MEM_W_EN_in = 1; Val_Rm_in = 32'hDEAD_BEEF;
    step("flush_over_freeze");
    freeze = 0; flush = 0;

    // Hazard bubble: control dropped, datapath copied.
    clear_inputs();
    valid_in = 0; B_in = 1; PC_in = 32'h40;
    step("hazard_bubble");

    // Mixed traffic.
    for (int i = 0; i < 40; i++) begin
      random_inputs();
      freeze = ($urandom_range(3) == 0);
      flush  = ($urandom_range(6) == 0);
      step("random");
    end

    // Async reset mid-cycle while stalled and flushing with all inputs high.
    @(posedge clk);
    sb.delete();
    freeze = 1; flush = 1; valid_in = 1;
    WB_EN_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 1; B_in = 1; S_in = 1;
    EXE_CMD_in = '1; PC_in = '1; Val_Rn_in = '1; Val_Rm_in = '1; imm_in = 1;
    Shift_operand_in = '1; Signed_imm_24_in = '1; Dest_in = '1; SR_in = '1;
    src1_in = '1; src2_in = '1;
    #3;
    rst = 0;
    #1;
    m = '0;
    compare("async_reset", m);
    @(posedge clk);
    #1;
    compare("reset_held", m);
    @(negedge clk);
    rst = 1;

    // Saturation: 20 consecutive hazard bubbles from zero.
    clear_inputs();
    for (int i = 0; i < 20; i++) step("saturate");
    check("sat_final", 64'(bubble_cnt), 64'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
